mul_sequencer: RTL

MUL_SEQUENCER -- requirements
Module: mul_sequencer

---
 rtl/mul_sequencer_if.sv | 28 ++
 rtl/mul_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_sequencer_if.sv
// Request/response/flush bundle for mul_sequencer.
// The master side issues multiply requests and consumes results; the slave side is the sequencer.
interface mul_sequencer_if;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [1:0]  i_req_op;
    logic [31:0] i_req_rs1;
    logic [31:0] i_req_rs2;
    logic [4:0]  i_req_tag;
    logic        i_flush;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_data;
    logic [4:0]  o_rsp_tag;
    logic        o_busy;

    modport master (
        output i_req_valid, i_req_op, i_req_rs1, i_req_rs2, i_req_tag,
        output i_flush, i_rsp_ready,
        input  o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_tag, o_busy
    );

    modport slave (
        input  i_req_valid, i_req_op, i_req_rs1, i_req_rs2, i_req_tag,
        input  i_flush, i_rsp_ready,
        output o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_tag, o_busy
    );
endinterface

// File: rtl/mul_sequencer.sv
// RISC-V style MUL/MULH/MULHSU/MULHU sequencer: a 4-stage 33x33 signed multiplier,
// a reset-cleared tracking pipe running alongside it, and a 6-entry result FIFO.
// Acceptance is limited by occupancy (in flight + queued) so every accepted request
// owns a FIFO slot before it is issued.

// Four-stage pipelined 33x33 signed multiplier. Datapath and valid pipe carry no reset.
module mul_sequencer_mult (
    input  logic               i_clk,
    input  logic               i_valid,
    input  logic signed [32:0] i_a,
    input  logic signed [32:0] i_b,
    output logic               o_valid,
    output logic        [63:0] o_product
);
    logic signed [32:0] a_q;
    logic signed [32:0] b_q;
    logic        [63:0] prod_d;
    logic        [63:0] p2_q;
    logic        [63:0] p3_q;
    logic        [63:0] p4_q;
    logic        [3:0]  vld_q;

    // Full product; the low 64 bits of the 66-bit signed product hold every result field we need.
    always_comb begin
        prod_d = 64'(a_q) * 64'(b_q);
    end

    // Valid pipe shifts every cycle; data stages only load behind a valid token.
    always_ff @(posedge i_clk) begin
        vld_q <= {vld_q[2:0], i_valid};
        if (i_valid) begin
            a_q <= i_a;
            b_q <= i_b;
        end
        if (vld_q[0]) p2_q <= prod_d;
        if (vld_q[1]) p3_q <= p2_q;
        if (vld_q[2]) p4_q <= p3_q;
    end

    // Output taps.
    always_comb begin
        o_valid   = vld_q[3];
        o_product = p4_q;
    end
endmodule

module mul_sequencer (
    input  logic           i_clk,
    input  logic           i_rst_n,
    mul_sequencer_if.slave bus
);
    localparam int unsigned PipeStages = 4;
    localparam int unsigned RspDepth   = 6;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } op_e;

    typedef struct packed {
        logic       valid;
        op_e        op;
        logic [4:0] tag;
    } trk_t;

    typedef struct packed {
        logic [4:0]  tag;
        logic [31:0] data;
    } rsp_t;

    trk_t               trk_q [PipeStages];
    trk_t               trk_d [PipeStages];
    rsp_t               fifo_mem [RspDepth];
    logic [2:0]         wr_ptr_q, wr_ptr_d;
    logic [2:0]         rd_ptr_q, rd_ptr_d;
    logic [2:0]         count_q, count_d;
    logic [3:0]         occ;
    logic               req_ready;
    logic               rsp_valid;
    logic               accept;
    logic               push;
    logic               pop;
    op_e                req_op;
    logic signed [32:0] mul_a;
    logic signed [32:0] mul_b;
    logic               mul_valid_unused;
    logic        [63:0] mul_product;
    rsp_t               push_entry;

    function automatic logic [2:0] next_ptr(input logic [2:0] p);
        return (p == 3'(RspDepth - 1)) ? 3'd0 : p + 3'd1;
    endfunction

    // Occupancy from registered state only: tracked in-flight tokens plus queued results.
    always_comb begin
        occ = {1'b0, count_q};
        for (int unsigned i = 0; i < PipeStages; i++) begin
            occ = occ + {3'b000, trk_q[i].valid};
        end
    end

    // Request handshake; ready never looks at i_req_valid or i_rsp_ready.
    always_comb begin
        req_ready = i_rst_n && (occ < 4'(RspDepth)) && !bus.i_flush;
        accept    = bus.i_req_valid && req_ready;
        req_op    = op_e'(bus.i_req_op);
    end

    // Operand extension: only the signed halves of MULH/MULHSU get a sign bit.
    always_comb begin
        mul_a = {1'b0, bus.i_req_rs1};
        mul_b = {1'b0, bus.i_req_rs2};
        case (req_op)
            OP_MULH: begin
                mul_a = {bus.i_req_rs1[31], bus.i_req_rs1};
                mul_b = {bus.i_req_rs2[31], bus.i_req_rs2};
            end
            OP_MULHSU: mul_a = {bus.i_req_rs1[31], bus.i_req_rs1};
            default: ;
        endcase
    end

    mul_sequencer_mult u_mult (
        .i_clk     (i_clk),
        .i_valid   (accept),
        .i_a       (mul_a),
        .i_b       (mul_b),
        .o_valid   (mul_valid_unused),
        .o_product (mul_product)
    );

    // Tracking pipe mirrors the multiplier latency; flush kills every token so stale products are dropped.
    always_comb begin
        trk_d[0] = '{valid: accept, op: req_op, tag: bus.i_req_tag};
        for (int unsigned i = 1; i < PipeStages; i++) begin
            trk_d[i] = trk_q[i - 1];
        end
        if (bus.i_flush) begin
            for (int unsigned i = 0; i < PipeStages; i++) begin
                trk_d[i].valid = 1'b0;
            end
        end
    end

    // Tracking pipe register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < PipeStages; i++) begin
                trk_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < PipeStages; i++) begin
                trk_q[i] <= trk_d[i];
            end
        end
    end

    // FIFO control: push from the last tracking stage, pop on handshake, flush clears all.
    always_comb begin
        push       = trk_q[PipeStages - 1].valid;
        rsp_valid  = (count_q != 3'd0);
        pop        = rsp_valid && bus.i_rsp_ready;
        push_entry.tag  = trk_q[PipeStages - 1].tag;
        push_entry.data = (trk_q[PipeStages - 1].op == OP_MUL) ? mul_product[31:0]
                                                               : mul_product[63:32];
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = next_ptr(wr_ptr_q);
            if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_d = count_q + 3'd1;
                2'b01:   count_d = count_q - 3'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // FIFO pointer/count registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage; when full, a push lands in the slot being popped this same cycle.
    always_ff @(posedge i_clk) begin
        if (push && !bus.i_flush) fifo_mem[wr_ptr_q] <= push_entry;
    end

    // Response and status outputs.
    always_comb begin
        bus.o_req_ready = req_ready;
        bus.o_rsp_valid = rsp_valid;
        bus.o_rsp_data  = fifo_mem[rd_ptr_q].data;
        bus.o_rsp_tag   = fifo_mem[rd_ptr_q].tag;
        bus.o_busy      = (occ != 4'd0);
    end
endmodule
